push_btn: RTL and testbench

- Instruction-driven push-button peripheral; sits on the controller's 12-bit instruction bus beside other peripherals.
- Samples a raw button input and remembers any press in a sticky flag.
- Returns that flag to the controller on a "read button status" instruction, then clears it.
- Enters a sticky error state on any undefined opcode; only reset leaves it.

---
 rtl/push_btn_pkg.sv | 23 ++
 rtl/push_btn_edge.sv | 22 ++
 rtl/push_btn.sv | 65 ++++++
 tb/tb_push_btn.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/push_btn_pkg.sv
// Shared definitions for the push-button peripheral: opcodes, FSM states,
// and instruction field layout.
package push_btn_pkg;

    localparam int unsigned INST_W  = 12;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned OPC_LSB = 8;

    localparam logic [OPC_W-1:0] PushBtn_NOP = 4'h0;
    localparam logic [OPC_W-1:0] PushBtn_RBS = 4'h1;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        READY = 2'd1,
        ERROR = 2'd2
    } state_e;

    function automatic logic [OPC_W-1:0] inst_opcode(input logic [INST_W-1:0] inst);
        return inst[OPC_LSB +: OPC_W];
    endfunction

endpackage

// File: rtl/push_btn_edge.sv
// Button sample register and rising-edge detector; the pulse is combinational
// so an RBS on the same edge as the press still observes it.
module push_btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic rise_c
);

    logic button_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            button_q <= 1'b0;
        end else begin
            button_q <= button;
        end
    end

    assign rise_c = button & ~button_q;

endmodule

// File: rtl/push_btn.sv
// Instruction-driven push-button peripheral: sticky press flag read and
// cleared by RBS, terminal error state on any undefined opcode.
module push_btn
    import push_btn_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [INST_W-1:0] inst,
    input  logic              inst_en,
    input  logic              button,
    output logic              button_status
);

    state_e           state_q;
    logic             flag_q;
    logic             press_c;
    logic [OPC_W-1:0] opcode_c;
    logic             unused_imm_c;

    push_btn_edge u_edge (
        .clock  (clock),
        .reset  (reset),
        .button (button),
        .rise_c (press_c)
    );

    assign opcode_c     = inst_opcode(inst);
    assign unused_imm_c = ^inst[IMM_W-1:0];

    // A press coinciding with RBS is reported by that read and not re-latched.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= RESET;
            flag_q        <= 1'b0;
            button_status <= 1'b0;
        end else begin
            case (state_q)
                RESET: begin
                    state_q <= READY;
                    flag_q  <= flag_q | press_c;
                end
                READY: begin
                    if (inst_en && (opcode_c == PushBtn_RBS)) begin
                        button_status <= flag_q | press_c;
                        flag_q        <= 1'b0;
                    end else begin
                        flag_q <= flag_q | press_c;
                        if (inst_en && (opcode_c != PushBtn_NOP)) begin
                            state_q       <= ERROR;
                            button_status <= 1'b0;
                        end
                    end
                end
                ERROR: begin
                    button_status <= 1'b0;
                end
                default: begin
                    state_q       <= ERROR;
                    button_status <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_push_btn.sv
// Self-checking bench for push_btn: scripted instruction/button steps with a
// scoreboard of expected button_status values.
module tb_push_btn;

    logic        clock;
    logic        reset;
    logic [11:0] inst;
    logic        inst_en;
    logic        button;
    logic        button_status;

    int n_tests = 0;
    int n_fail  = 0;
    bit sb[$];

    localparam logic [11:0] I_NOP = 12'h000;
    localparam logic [11:0] I_RBS = 12'h1A5;
    localparam logic [11:0] I_BAD = 12'hBAE;

    push_btn dut (
        .clock         (clock),
        .reset         (reset),
        .inst          (inst),
        .inst_en       (inst_en),
        .button        (button),
        .button_status (button_status)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit [15:0] mk(input bit exp, input bit btn, input bit en, input bit [11:0] ins);
        return {exp, btn, en, 1'b0, ins};
    endfunction

    task automatic apply(input bit [11:0] ins, input bit en, input bit btn);
        @(negedge clock);
        inst    = ins;
        inst_en = en;
        button  = btn;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bit exp;
        reset = 1'b0; inst = I_NOP; inst_en = 1'b0; button = 1'b0;
        repeat (2) @(negedge clock);
        sb.push_back(1'b0);
        exp = sb.pop_front();
        n_tests++;
        if (button_status !== exp) begin
            n_fail++;
            $display("FAIL reset_hold: got %b want %b", button_status, exp);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        bit [15:0] st[$];
        bit exp;
        st = '{mk(0,0,1,I_NOP), mk(0,0,1,I_NOP), mk(0,0,1,I_RBS), mk(0,0,1,I_RBS)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL basic[%0d]: got %b want %b", i, button_status, exp);
            end
        end
    endtask

    task automatic test_press();
        bit [15:0] st[$];
        bit exp;
        st = '{mk(0,1,1,I_NOP), mk(0,1,1,I_NOP), mk(0,0,1,I_NOP),
               mk(1,0,1,I_RBS), mk(1,0,1,I_NOP), mk(0,0,1,I_RBS)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL press[%0d]: got %b want %b", i, button_status, exp);
            end
        end
    endtask

    task automatic test_hold();
        bit [15:0] st[$];
        bit exp;
        st = '{mk(0,1,1,I_NOP), mk(1,1,1,I_RBS), mk(0,1,1,I_RBS),
               mk(0,1,1,I_RBS), mk(0,0,1,I_NOP)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL hold[%0d]: got %b want %b", i, button_status, exp);
            end
        end
    endtask

    task automatic test_multi_press();
        bit [15:0] st[$];
        bit exp;
        st = '{mk(0,1,0,I_BAD), mk(0,0,0,I_BAD), mk(0,1,0,I_NOP), mk(0,0,1,I_NOP),
               mk(0,1,1,I_NOP), mk(0,0,1,I_NOP), mk(1,0,1,I_RBS), mk(0,0,1,I_RBS)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL multi[%0d]: got %b want %b", i, button_status, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit [15:0] st[$];
        bit exp;
        st = '{mk(1,1,1,I_RBS), mk(1,1,0,I_RBS), mk(0,1,1,I_RBS), mk(0,0,1,I_NOP)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL coincident[%0d]: got %b want %b", i, button_status, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit [15:0] st[$];
        bit exp;
        st = '{mk(0,1,1,I_NOP), mk(1,0,1,I_RBS), mk(1,1,1,I_NOP)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL midrst_pre[%0d]: got %b want %b", i, button_status, exp);
            end
        end
        @(negedge clock);
        reset  = 1'b0;
        button = 1'b0;
        #1;
        sb.push_back(1'b0);
        exp = sb.pop_front();
        n_tests++;
        if (button_status !== exp) begin
            n_fail++;
            $display("FAIL midrst_async: got %b want %b", button_status, exp);
        end
        @(negedge clock);
        reset = 1'b1;
        st = '{mk(0,0,1,I_NOP), mk(0,0,1,I_RBS)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL midrst_post[%0d]: got %b want %b", i, button_status, exp);
            end
        end
    endtask

    task automatic test_error();
        bit [15:0] st[$];
        bit exp;
        st = '{mk(0,1,1,I_NOP), mk(1,0,1,I_RBS), mk(0,0,1,I_BAD), mk(0,1,1,I_NOP),
               mk(0,1,1,I_RBS), mk(0,0,1,I_RBS), mk(0,1,1,I_RBS)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL error[%0d]: got %b want %b", i, button_status, exp);
            end
        end
        @(negedge clock);
        reset  = 1'b0;
        button = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        st = '{mk(0,0,1,I_NOP), mk(0,0,1,I_RBS), mk(0,1,1,I_NOP), mk(1,0,1,I_RBS)};
        foreach (st[i]) begin
            sb.push_back(st[i][15]);
            apply(st[i][11:0], st[i][13], st[i][14]);
            exp = sb.pop_front();
            n_tests++;
            if (button_status !== exp) begin
                n_fail++;
                $display("FAIL error_recover[%0d]: got %b want %b", i, button_status, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_press();
        test_hold();
        test_multi_press();
        test_back_to_back();
        test_mid_reset();
        test_error();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
